sl3p_deskew_align: RTL and testbench

Parametrised lane-deskew controller for the SL3P receive path. It sits after per-lane word lock and alignment-marker detection. It measures the per-lane arrival offset of alignment-marker pings inside a bounded skew window, and derives a per-lane delay setting that an external delay line uses to align all lanes. It qualifies that setting over several marker periods before declaring lock, and drops lock only after a configurable run of bad periods.

---
 rtl/sl3p_deskew_pkg.sv | 18 +
 rtl/sl3p_skew_window.sv | 73 +++++++
 rtl/sl3p_deskew_align.sv | 171 +++++++++++++++++
 tb/tb_sl3p_deskew_align.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/sl3p_deskew_pkg.sv
// Shared types and helpers for the SL3P lane-deskew controller.
package sl3p_deskew_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    localparam int STATS_W = 16;

    // Width of a per-lane delay / arrival value; never below one bit.
    function automatic int calc_dw(input int max_skew);
        return (max_skew < 1) ? 1 : $clog2(max_skew + 1);
    endfunction

endpackage

// File: rtl/sl3p_skew_window.sv
// Skew window: opens on the first marker ping, records per-lane arrival
// counts over MAX_SKEW+1 cycles, and reports missing/duplicate lanes on close.
module sl3p_skew_window
    import sl3p_deskew_pkg::*;
#(
    parameter int NUM_LN   = 16,
    parameter int MAX_SKEW = 7,
    parameter int DW       = calc_dw(MAX_SKEW)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [NUM_LN-1:0]    ping,
    output logic                 win_done,
    output logic [NUM_LN*DW-1:0] arrival,
    output logic [NUM_LN-1:0]    flags
);

    logic                 open_q;
    logic [DW-1:0]        cnt_q;
    logic [NUM_LN-1:0]    seen_q, dup_q;
    logic [NUM_LN*DW-1:0] arr_q;

    logic                 active, closing;
    logic [DW-1:0]        cur_cnt;
    logic [NUM_LN-1:0]    seen_d, dup_d;
    logic [NUM_LN*DW-1:0] arr_d;

    // The opening cycle counts as position 0 even though open_q is still low.
    always_comb begin
        cur_cnt = open_q ? cnt_q : '0;
        active  = open_q || (|ping);
        closing = active && (cur_cnt == DW'(MAX_SKEW));
        seen_d  = seen_q | ping;
        dup_d   = dup_q | (seen_q & ping);
        arr_d   = arr_q;
        for (int i = 0; i < NUM_LN; i++) begin
            if (ping[i] && !seen_q[i]) arr_d[i*DW +: DW] = cur_cnt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (clr) begin
            open_q   <= 1'b0;
            cnt_q    <= '0;
            seen_q   <= '0;
            dup_q    <= '0;
            arr_q    <= '0;
            win_done <= 1'b0;
            arrival  <= '0;
            flags    <= '0;
        end else begin
            win_done <= closing;
            if (closing) begin
                arrival <= arr_d;
                flags   <= ~seen_d | dup_d;
                open_q  <= 1'b0;
                cnt_q   <= '0;
                seen_q  <= '0;
                dup_q   <= '0;
                arr_q   <= '0;
            end else if (active) begin
                open_q <= 1'b1;
                cnt_q  <= cur_cnt + 1'b1;
                seen_q <= seen_d;
                dup_q  <= dup_d;
                arr_q  <= arr_d;
            end
        end
    end

endmodule

// File: rtl/sl3p_deskew_align.sv
// SL3P lane-deskew controller: window evaluation, delay qualification and lock FSM.
// Optional bad-window statistics counter enabled by SL3P_DESKEW_STATS_EN.
module sl3p_deskew_align
    import sl3p_deskew_pkg::*;
#(
    parameter int NUM_LN     = 16,
    parameter int MAX_SKEW   = 7,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2
) (
    input  logic                                 clk,
    input  logic                                 srst,
    input  logic                                 word_locked,
    input  logic [NUM_LN-1:0]                    am_ping,
    output logic [NUM_LN*calc_dw(MAX_SKEW)-1:0]  lane_dly,
    output logic                                 dly_valid,
    output logic                                 deskew_locked,
    output logic [NUM_LN-1:0]                    fallback_req
`ifdef SL3P_DESKEW_STATS_EN
   ,output logic [STATS_W-1:0]                   bad_win_cnt
`endif
);

    localparam int DW = calc_dw(MAX_SKEW);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    logic                 clr;
    logic [NUM_LN-1:0]    am_ping_r;
    logic                 win_done;
    logic [NUM_LN*DW-1:0] arrival, cand;
    logic [NUM_LN-1:0]    flags;
    logic [DW-1:0]        max_arr;
    logic                 good, bad, match;

    state_t               state_q, state_d;
    logic [MW-1:0]        match_cnt_q, match_cnt_d;
    logic [BW-1:0]        bad_cnt_q, bad_cnt_d;
    logic [NUM_LN*DW-1:0] dly_d;
    logic                 valid_d, lock_d;
    logic [NUM_LN-1:0]    fb_d;

    assign clr = srst || !word_locked;

    always_ff @(posedge clk) begin
        if (clr) am_ping_r <= '0;
        else     am_ping_r <= am_ping;
    end

    sl3p_skew_window #(
        .NUM_LN   (NUM_LN),
        .MAX_SKEW (MAX_SKEW),
        .DW       (DW)
    ) u_window (
        .clk      (clk),
        .clr      (clr),
        .ping     (am_ping_r),
        .win_done (win_done),
        .arrival  (arrival),
        .flags    (flags)
    );

    always_comb begin
        max_arr = '0;
        for (int i = 0; i < NUM_LN; i++) begin
            if (arrival[i*DW +: DW] > max_arr) max_arr = arrival[i*DW +: DW];
        end
        cand = '0;
        for (int i = 0; i < NUM_LN; i++) cand[i*DW +: DW] = max_arr - arrival[i*DW +: DW];
        good  = win_done && (flags == '0);
        bad   = win_done && (|flags);
        match = good && (cand == lane_dly);
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        dly_d       = lane_dly;
        valid_d     = dly_valid;
        lock_d      = deskew_locked;
        fb_d        = '0;
        match_cnt_d = match_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        case (state_q)
            IDLE: if (word_locked) state_d = SEARCH;
            SEARCH: begin
                if (good) begin
                    dly_d       = cand;
                    match_cnt_d = MW'(1);
                    if (LOCK_CNT == 1) begin
                        state_d   = LOCKED;
                        valid_d   = 1'b1;
                        lock_d    = 1'b1;
                        bad_cnt_d = '0;
                    end else begin
                        state_d = VERIFY;
                    end
                end else if (bad) begin
                    fb_d = flags;
                end
            end
            VERIFY: begin
                if (match) begin
                    if ((match_cnt_q + 1'b1) == MW'(LOCK_CNT)) begin
                        state_d   = LOCKED;
                        valid_d   = 1'b1;
                        lock_d    = 1'b1;
                        bad_cnt_d = '0;
                    end
                    match_cnt_d = match_cnt_q + 1'b1;
                end else if (good) begin
                    dly_d       = cand;
                    match_cnt_d = MW'(1);
                end else if (bad) begin
                    state_d = SEARCH;
                    fb_d    = flags;
                end
            end
            LOCKED: begin
                if (match) begin
                    bad_cnt_d = '0;
                end else if (win_done) begin
                    if ((bad_cnt_q + 1'b1) == BW'(UNLOCK_CNT)) begin
                        state_d     = SEARCH;
                        valid_d     = 1'b0;
                        lock_d      = 1'b0;
                        bad_cnt_d   = '0;
                        match_cnt_d = '0;
                    end else begin
                        bad_cnt_d = bad_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= IDLE;
            lane_dly      <= '0;
            dly_valid     <= 1'b0;
            deskew_locked <= 1'b0;
            fallback_req  <= '0;
            match_cnt_q   <= '0;
            bad_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            lane_dly      <= dly_d;
            dly_valid     <= valid_d;
            deskew_locked <= lock_d;
            fallback_req  <= fb_d;
            match_cnt_q   <= match_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
        end
    end

`ifdef SL3P_DESKEW_STATS_EN
    // Survives word_locked drops; only srst clears the statistics.
    always_ff @(posedge clk) begin
        if (srst) begin
            bad_win_cnt <= '0;
        end else if (word_locked && state_q != IDLE && bad_win_cnt != '1 &&
                     (bad || (good && !match && state_q inside {VERIFY, LOCKED}))) begin
            bad_win_cnt <= bad_win_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sl3p_deskew_align.sv
// Directed scoreboard bench for sl3p_deskew_align (4 lanes, MAX_SKEW=7, LOCK_CNT=3, UNLOCK_CNT=2).
module tb_sl3p_deskew_align;

    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          srst, word_locked;
    logic [NL-1:0] am_ping;
    logic [11:0]   lane_dly;
    logic          dly_valid, deskew_locked;
    logic [NL-1:0] fallback_req;
`ifdef SL3P_DESKEW_STATS_EN
    logic [15:0]   bad_win_cnt;
`endif

    always #5 clk = ~clk;

    sl3p_deskew_align #(
        .NUM_LN(NL), .MAX_SKEW(7), .LOCK_CNT(3), .UNLOCK_CNT(2)
    ) dut (
        .clk           (clk),
        .srst          (srst),
        .word_locked   (word_locked),
        .am_ping       (am_ping),
        .lane_dly      (lane_dly),
        .dly_valid     (dly_valid),
        .deskew_locked (deskew_locked),
        .fallback_req  (fallback_req)
`ifdef SL3P_DESKEW_STATS_EN
       ,.bad_win_cnt   (bad_win_cnt)
`endif
    );

    typedef struct {
        int          due;
        logic [11:0] dly;
        logic [3:0]  fb;
        logic        lk;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [11:0] DLY_L2 = 12'h61B;  // lanes 0,1,3 = 3, lane 2 = 0

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_at(input int due, input logic [11:0] dly, input logic [3:0] fb,
                             input logic lk, input string tag);
        exp_t e;
        e.due = due; e.dly = dly; e.fb = fb; e.lk = lk; e.tag = tag;
        sb.push_back(e);
    endtask

    // Offsets are cycles after the window start; -1 means the lane never pings.
    task automatic run_win(input int o0, input int o1, input int o2, input int o3, input int len);
        int   off[NL];
        exp_t e;
        off[0] = o0; off[1] = o1; off[2] = o2; off[3] = o3;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == i) begin
                e = sb.pop_front();
                chk({e.tag, "_dly"},   lane_dly,      e.dly);
                chk({e.tag, "_fb"},    fallback_req,  e.fb);
                chk({e.tag, "_lock"},  deskew_locked, e.lk);
                chk({e.tag, "_valid"}, dly_valid,     e.lk);
            end else begin
                chk("fb_quiet", fallback_req, 0);
            end
            for (int l = 0; l < NL; l++) am_ping[l] = (off[l] == i);
        end
        am_ping = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dly"},   lane_dly,      0);
        chk({tag, "_fb"},    fallback_req,  0);
        chk({tag, "_lock"},  deskew_locked, 0);
        chk({tag, "_valid"}, dly_valid,     0);
    endtask

    initial begin
        srst        = 1'b1;
        word_locked = 1'b1;
        am_ping     = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        srst = 1'b0;

        // Aligned lanes: delay 0, lock on the third matching window.
        expect_at(10, 12'h000, 4'b0000, 1'b0, "al_w1"); run_win(0, 0, 0, 0, 16);
        expect_at(10, 12'h000, 4'b0000, 1'b0, "al_w2"); run_win(0, 0, 0, 0, 16);
        expect_at(10, 12'h000, 4'b0000, 1'b1, "al_w3"); run_win(0, 0, 0, 0, 16);

        // Locked: a single mismatch is tolerated, two bad windows unlock.
        expect_at(10, 12'h000, 4'b0000, 1'b1, "lk_mis");  run_win(0, 0, 3, 0, 16);
        expect_at(10, 12'h000, 4'b0000, 1'b1, "lk_good"); run_win(0, 0, 0, 0, 16);
        expect_at(10, 12'h000, 4'b0000, 1'b1, "lk_bad1"); run_win(0, -1, 0, 0, 16);
        expect_at(10, 12'h000, 4'b0000, 1'b0, "lk_bad2"); run_win(0, -1, 0, 0, 16);

        // Lane 2 three cycles late.
        expect_at(10, DLY_L2, 4'b0000, 1'b0, "sk_w1"); run_win(0, 0, 3, 0, 16);
        expect_at(10, DLY_L2, 4'b0000, 1'b0, "sk_w2"); run_win(0, 0, 3, 0, 16);
        expect_at(10, DLY_L2, 4'b0000, 1'b1, "sk_w3"); run_win(0, 0, 3, 0, 16);

        // Lane 1 silent: unlock quietly, then fallback pulses from SEARCH.
        expect_at(10, DLY_L2, 4'b0000, 1'b1, "ms_lk1"); run_win(0, -1, 0, 0, 16);
        expect_at(10, DLY_L2, 4'b0000, 1'b0, "ms_lk2"); run_win(0, -1, 0, 0, 16);
        expect_at(10, DLY_L2, 4'b0010, 1'b0, "ms_s1");  run_win(0, -1, 0, 0, 16);
        expect_at(10, DLY_L2, 4'b0010, 1'b0, "ms_s2");  run_win(0, -1, 0, 0, 16);

        // Lane 3 beyond the window: flagged, then its late ping opens a window alone.
        expect_at(10, DLY_L2, 4'b1000, 1'b0, "late_w1");
        expect_at(19, DLY_L2, 4'b0111, 1'b0, "late_w2");
        run_win(0, 0, 0, 9, 24);

        // Enter VERIFY with a non-zero delay, then drop word_locked.
        expect_at(10, 12'h000, 4'b0000, 1'b0, "vf_w1"); run_win(0, 0, 0, 0, 16);
        expect_at(10, DLY_L2,  4'b0000, 1'b0, "vf_w2"); run_win(0, 0, 3, 0, 16);
        @(negedge clk);
        word_locked = 1'b0;
        @(negedge clk);
        chk_all_zero("wl_drop");
        word_locked = 1'b1;

        expect_at(10, DLY_L2, 4'b0000, 1'b0, "rs_w1"); run_win(0, 0, 3, 0, 16);
        expect_at(10, DLY_L2, 4'b0000, 1'b0, "rs_w2"); run_win(0, 0, 3, 0, 16);
        expect_at(10, DLY_L2, 4'b0000, 1'b1, "rs_w3"); run_win(0, 0, 3, 0, 16);

        // Synchronous reset while locked.
        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        chk_all_zero("srst_lk");
        srst = 1'b0;

        chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
